// File: rtl/cp0_unit_if.sv
// Bus between the M stage and coprocessor 0: mfc0/mtc0 access, exception
// information carried down the pipeline, interrupt lines and the flush request.
// The pipeline drives everything except DOut, EPCOut and Req. There is no
// valid/ready handshake: WE qualifies a write in the cycle it is high, and Req
// is a combinational, single-cycle flush strobe. A request is taken on the
// edge that ends the cycle in which Req was observed high.
interface cp0_unit_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] M_PC;
    logic [4:0]  M_EXCCode;
    logic        M_DelaySlot;
    logic        EXLClr;
    logic [5:0]  HWInt;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic        Req;

    modport master (
        output A1, A2, DIn, WE, M_PC, M_EXCCode, M_DelaySlot, EXLClr, HWInt,
        input  DOut, EPCOut, Req
    );

    modport slave (
        input  A1, A2, DIn, WE, M_PC, M_EXCCode, M_DelaySlot, EXLClr, HWInt,
        output DOut, EPCOut, Req
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0 for the 5-stage MIPS core, sitting beside the M stage.
// Holds SR, Cause, EPC and PRId, raises Req for exceptions and interrupts,
// and services mfc0/mtc0/eret.
// Optional build macro CP0_TIMER_EN adds Count (reg 9) and Compare (reg 11)
// with a sticky timer pending flag folded into interrupt line 5.
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h2021_0007
) (
    input  logic      clk,
    input  logic      reset,
    cp0_unit_if.slave bus
);
    // SR fields
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    // Cause fields
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    // EPC
    logic [31:0] epc;

    logic [5:0]  hw_int_eff;
    logic        int_req;
    logic        exc_req;
    logic        req;
    logic        wr_sr;
    logic        wr_epc;

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pend;
    logic        wr_count;
    logic        wr_compare;

    // Timer pending drives interrupt line 5 alongside the external line.
    always_comb begin
        hw_int_eff    = bus.HWInt;
        hw_int_eff[5] = bus.HWInt[5] | timer_pend;
    end
`else
    assign hw_int_eff = bus.HWInt;
`endif

    // Request logic: live interrupt lines, blocked entirely while EXL is set.
    assign int_req = (|(hw_int_eff & im)) & ie & ~exl;
    assign exc_req = (bus.M_EXCCode != 5'd0) & ~exl;
    assign req     = int_req | exc_req;
    assign bus.Req = req;
    assign bus.EPCOut = epc;

    // mtc0 is suppressed whenever a request is being taken this cycle.
    assign wr_sr  = bus.WE & ~req & (bus.A2 == 5'd12);
    assign wr_epc = bus.WE & ~req & (bus.A2 == 5'd14);

    // SR, Cause and EPC update: exception entry wins over mtc0, eret clears EXL.
    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= hw_int_eff;
            if (req) begin
                exl      <= 1'b1;
                bd       <= bus.M_DelaySlot;
                exc_code <= int_req ? 5'd0 : bus.M_EXCCode;
                epc      <= bus.M_DelaySlot ? (bus.M_PC - 32'd4) : bus.M_PC;
            end else begin
                if (wr_sr) begin
                    im  <= bus.DIn[15:10];
                    exl <= bus.DIn[1];
                    ie  <= bus.DIn[0];
                end
                if (bus.EXLClr) begin
                    exl <= 1'b0;
                end
                if (wr_epc) begin
                    epc <= bus.DIn;
                end
            end
        end
    end

`ifdef CP0_TIMER_EN
    assign wr_count   = bus.WE & ~req & (bus.A2 == 5'd9);
    assign wr_compare = bus.WE & ~req & (bus.A2 == 5'd11);

    // Free-running counter, compare register and sticky match flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            compare    <= '0;
            timer_pend <= 1'b0;
        end else begin
            count <= wr_count ? bus.DIn : (count + 32'd1);
            if (wr_compare) begin
                compare    <= bus.DIn;
                timer_pend <= 1'b0;
            end else if ((count == compare) && (compare != 32'd0)) begin
                timer_pend <= 1'b1;
            end
        end
    end
`endif

    // mfc0 read mux; no bypass of a same-cycle mtc0.
    always_comb begin
        bus.DOut = 32'h0;
        case (bus.A1)
            5'd12: bus.DOut = {16'h0, im, 8'h0, exl, ie};
            5'd13: bus.DOut = {bd, 15'h0, ip, 3'h0, exc_code, 2'h0};
            5'd14: bus.DOut = epc;
            5'd15: bus.DOut = PRID_VALUE;
`ifdef CP0_TIMER_EN
            5'd9:  bus.DOut = count;
            5'd11: bus.DOut = compare;
`endif
            default: bus.DOut = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: a table of cycle-by-cycle steps whose expected
// Req, DOut and EPCOut values are worked out by hand, followed by short
// sequences for the timer (CP0_TIMER_EN) or for ignored timer accesses.
module tb_cp0_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cp0_unit_if bus();

    cp0_unit #(.PRID_VALUE(32'h2021_0007)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  a2;
        logic [31:0] din;
        logic [4:0]  a1;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        ds;
        logic        clr;
        logic [5:0]  hw;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [4:0] a2, logic [31:0] din,
                                logic [4:0] a1, logic [31:0] pc, logic [4:0] exc,
                                logic ds, logic clr, logic [5:0] hw,
                                logic req, logic [31:0] dout, logic [31:0] epc);
        vec_t v;
        v.we = we; v.a2 = a2; v.din = din; v.a1 = a1; v.pc = pc; v.exc = exc;
        v.ds = ds; v.clr = clr; v.hw = hw; v.req = req; v.dout = dout; v.epc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.WE = 1'b0; bus.A2 = 5'd0; bus.DIn = 32'h0; bus.A1 = 5'd0;
        bus.M_PC = 32'h0; bus.M_EXCCode = 5'd0; bus.M_DelaySlot = 1'b0;
        bus.EXLClr = 1'b0; bus.HWInt = 6'd0;
    endtask

    // Drive one step at the falling edge; outputs are sampled 2 time units later.
    task automatic drive(input vec_t v);
        @(negedge clk);
        bus.WE = v.we; bus.A2 = v.a2; bus.DIn = v.din; bus.A1 = v.a1;
        bus.M_PC = v.pc; bus.M_EXCCode = v.exc; bus.M_DelaySlot = v.ds;
        bus.EXLClr = v.clr; bus.HWInt = v.hw;
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1'b1;

        //            we a2     din           a1     pc            exc    ds clr hw        req dout          epc
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd12, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0,        32'h0));         // 0 reset SR
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd13, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0,        32'h0));         // 1 reset Cause
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd14, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0,        32'h0));         // 2 reset EPC
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd15, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h2021_0007, 32'h0));        // 3 PRId
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd3,  32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0,        32'h0));         // 4 unmapped
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd12, 32'h0000_3010, 5'd10, 1, 0, 6'b000000, 1, 32'h0,        32'h0));        // 5 exc in slot
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd13, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h8000_0028, 32'h0000_300C)); // 6
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd14, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0000_300C, 32'h0000_300C)); // 7
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd12, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h2,        32'h0000_300C)); // 8 EXL
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd12, 32'h0,        5'd4,  0, 0, 6'b000000, 0, 32'h2,        32'h0000_300C)); // 9 nested blocked
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd13, 32'h0,        5'd4,  0, 1, 6'b000000, 0, 32'h8000_0028, 32'h0000_300C)); // 10 eret
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd12, 32'h0000_0100, 5'd4,  0, 0, 6'b000000, 1, 32'h0,        32'h0000_300C)); // 11 persists
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd13, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0000_0010, 32'h0000_0100)); // 12
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd14, 32'h0,        5'd0,  0, 1, 6'b000000, 0, 32'h0000_0100, 32'h0000_0100)); // 13 eret
        vecs.push_back(mk(1, 5'd12, 32'h0000_0401, 5'd12, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0,        32'h0000_0100)); // 14 mtc0 SR
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd12, 32'h0000_2000, 5'd0,  0, 0, 6'b000001, 1, 32'h0000_0401, 32'h0000_0100)); // 15 interrupt
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd13, 32'h0,        5'd0,  0, 0, 6'b000001, 0, 32'h0000_0400, 32'h0000_2000)); // 16 IP, code 0
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd14, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0000_2000, 32'h0000_2000)); // 17
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd12, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0000_0403, 32'h0000_2000)); // 18
        vecs.push_back(mk(1, 5'd12, 32'h0000_0003, 5'd13, 32'h0,        5'd0,  0, 1, 6'b000000, 0, 32'h0,        32'h0000_2000)); // 19 eret+mtc0
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd12, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0000_0001, 32'h0000_2000)); // 20 EXL cleared
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd12, 32'h0,        5'd0,  0, 0, 6'b000001, 0, 32'h0000_0001, 32'h0000_2000)); // 21 masked
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd13, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0000_0400, 32'h0000_2000)); // 22 IP delayed
        vecs.push_back(mk(1, 5'd14, 32'h0000_3400, 5'd14, 32'h0000_0500, 5'd12, 0, 0, 6'b000000, 1, 32'h0000_2000, 32'h0000_2000)); // 23 mtc0 suppressed
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd14, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0000_0500, 32'h0000_0500)); // 24
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd13, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0000_0030, 32'h0000_0500)); // 25
        vecs.push_back(mk(1, 5'd13, 32'hFFFF_FFFF, 5'd12, 32'h0,        5'd0,  0, 1, 6'b000000, 0, 32'h0000_0003, 32'h0000_0500)); // 26 Cause RO
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd13, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0000_0030, 32'h0000_0500)); // 27
        vecs.push_back(mk(1, 5'd14, 32'h1234_5678, 5'd14, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0000_0500, 32'h0000_0500)); // 28 mtc0 EPC
        vecs.push_back(mk(1, 5'd15, 32'h0,        5'd14, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h1234_5678, 32'h1234_5678)); // 29 PRId RO
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd15, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h2021_0007, 32'h1234_5678)); // 30
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd14, 32'h0000_3003, 5'd4,  1, 0, 6'b000000, 1, 32'h1234_5678, 32'h1234_5678)); // 31 misaligned
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd14, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h0000_2FFF, 32'h0000_2FFF)); // 32
        vecs.push_back(mk(0, 5'd0,  32'h0,        5'd13, 32'h0,        5'd0,  0, 0, 6'b000000, 0, 32'h8000_0010, 32'h0000_2FFF)); // 33

        // Reset block
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            chk($sformatf("row%0d_req", i),  {31'h0, bus.Req}, {31'h0, vecs[i].req});
            chk($sformatf("row%0d_dout", i), bus.DOut, vecs[i].dout);
            chk($sformatf("row%0d_epc", i),  bus.EPCOut, vecs[i].epc);
        end

`ifdef CP0_TIMER_EN
        begin
            bit seen;
            // eret together with SR = IM5 | IE, then Compare = 5, Count = 0
            drive(mk(1, 5'd12, 32'h0000_8001, 5'd0, 32'h0, 5'd0, 0, 1, 6'd0, 0, 32'h0, 32'h0));
            drive(mk(1, 5'd11, 32'h0000_0005, 5'd0, 32'h0, 5'd0, 0, 0, 6'd0, 0, 32'h0, 32'h0));
            chk("timer_no_req_before", {31'h0, bus.Req}, 32'h0);
            drive(mk(1, 5'd9,  32'h0000_0000, 5'd0, 32'h0, 5'd0, 0, 0, 6'd0, 0, 32'h0, 32'h0));
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                drive(mk(0, 5'd0, 32'h0, 5'd9, 32'h0, 5'd0, 0, 0, 6'd0, 0, 32'h0, 32'h0));
                if (bus.Req) begin
                    seen = 1'b1;
                    chk("timer_count_at_req", bus.DOut, 32'd6);
                end
            end
            chk("timer_req_seen", {31'h0, seen}, 32'h1);
            drive(mk(0, 5'd0, 32'h0, 5'd13, 32'h0, 5'd0, 0, 0, 6'd0, 0, 32'h0, 32'h0));
            chk("timer_cause_ip5", bus.DOut, 32'h0000_8000);
            drive(mk(1, 5'd11, 32'h0000_0007, 5'd11, 32'h0, 5'd0, 0, 0, 6'd0, 0, 32'h0, 32'h0));
            drive(mk(0, 5'd0, 32'h0, 5'd11, 32'h0, 5'd0, 0, 0, 6'd0, 0, 32'h0, 32'h0));
            chk("timer_compare_rd", bus.DOut, 32'd7);
            drive(mk(0, 5'd0, 32'h0, 5'd13, 32'h0, 5'd0, 0, 0, 6'd0, 0, 32'h0, 32'h0));
            chk("timer_pend_cleared", bus.DOut, 32'h0);
        end
`else
        // Timer registers absent: writes ignored, reads return zero.
        drive(mk(1, 5'd9,  32'h0000_0005, 5'd9,  32'h0, 5'd0, 0, 0, 6'd0, 0, 32'h0, 32'h0));
        drive(mk(1, 5'd11, 32'h0000_0005, 5'd9,  32'h0, 5'd0, 0, 0, 6'd0, 0, 32'h0, 32'h0));
        chk("notimer_count_rd", bus.DOut, 32'h0);
        drive(mk(0, 5'd0,  32'h0,         5'd11, 32'h0, 5'd0, 0, 0, 6'd0, 0, 32'h0, 32'h0));
        chk("notimer_compare_rd", bus.DOut, 32'h0);
`endif

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 for the 5-stage MIPS core; sits alongside the M stage.
- Consumes the exception code, delay-slot flag and PC that the pipeline registers carry down to M.
- Produces `Req`, the exception/interrupt request that flushes every pipeline register and steers fetch to the handler.
- Holds SR, Cause, EPC and PRId; services mfc0/mtc0/eret.

Parameters:
- PRID_VALUE, 32'h2021_0007, constant value returned on reads of register 15.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- A1  input  5  mfc0 read register number
- A2  input  5  mtc0 write register number
- DIn  input  32  mtc0 write data
- WE  input  1  mtc0 write enable (M stage)
- M_PC  input  32  PC of the instruction in M
- M_EXCCode  input  5  exception code of the M instruction; 0 = none
- M_DelaySlot  input  1  M instruction is in a branch delay slot
- EXLClr  input  1  eret in M
- HWInt  input  6  external interrupt lines, level-sensitive
- DOut  output  32  mfc0 read data (combinational)
- EPCOut  output  32  current EPC register value (eret target)
- Req  output  1  take exception/interrupt now (combinational)

Behaviour:
- Clock and reset: single clock `clk`. `reset` is synchronous, active-high, sampled on the rising edge.
- Reset values:
  - SR = 0 (IM = 0, EXL = 0, IE = 0).
  - Cause = 0.
  - EPC = 0.
  - Resulting outputs: Req = 0, EPCOut = 0.
- SR (reg 12): IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
- Cause (reg 13): BD = [31], IP = [15:10], ExcCode = [6:2]; all other bits read 0. Read-only to mtc0 (writes ignored).
- EPC (reg 14): 32-bit, fully writable by mtc0.
- PRId (reg 15): PRID_VALUE, read-only.
- Reads: any other register number reads 32'h0. DOut is a pure mux on A1 with no same-cycle write bypass.
- Request logic:
  - IntReq = (|(HWInt & IM)) & IE & !EXL
  - ExcReq = (M_EXCCode != 0) & !EXL
  - Req = IntReq | ExcReq. Interrupt has priority over exception.
- IP tracking: Cause.IP <= HWInt every cycle regardless of Req/EXL, so it is 1-cycle delayed. Req uses live HWInt, not IP.
- On a clock edge with Req = 1:
  - EXL <= 1.
  - Cause.BD <= M_DelaySlot.
  - Cause.ExcCode <= IntReq ? 5'd0 : M_EXCCode.
  - EPC <= M_DelaySlot ? M_PC - 4 : M_PC. No alignment masking; a misaligned PC for AdEL is preserved.
  - Any mtc0 (WE) in the same cycle is suppressed.
- On a clock edge with Req = 0:
  - WE & A2 == 12: IM, EXL, IE <= DIn fields.
  - WE & A2 == 14: EPC <= DIn.
- eret: EXLClr = 1 forces EXL <= 0, overriding a same-cycle mtc0 to SR for the EXL bit only; IM and IE are still written.
- Nesting: while EXL = 1, Req is held 0, so no nested exceptions occur. Req and EXLClr cannot both take effect in one cycle.
- Latency: Req asserts in the same cycle the condition appears. Register updates are visible the next cycle.

Optional Feature:
- Macro: CP0_TIMER_EN.
- When defined, adds:
  - Count (reg 9): increments by 1 every cycle; wraps 32'hFFFF_FFFF -> 0; mtc0 write loads it.
  - Compare (reg 11): mtc0-writable.
  - Internal sticky TimerPend, set when Count == Compare and Compare != 0; cleared by any mtc0 to Compare.
- With the timer, TimerPend is ORed into HWInt[5] for both IntReq and IP[15].
- Reset clears Count, Compare and TimerPend.
- When undefined: regs 9 and 11 read 0, writes to them are ignored, and HWInt is used unmodified.

Test Plan:
- Reset, then read regs 12/13/14/15 -> 0, 0, 0, PRID_VALUE; Req = 0.
- M_EXCCode = 5'd10, M_PC = 32'h0000_3010, M_DelaySlot = 1 -> Req = 1 same cycle; next cycle EXL = 1, Cause = 32'h8000_0028, EPC = 32'h0000_300C.
- mtc0 SR = 32'h0000_0401, HWInt = 6'b000001 -> Req = 1; next cycle ExcCode = 0, EXL = 1, IP[10] = 1, EPC = M_PC.
- With EXL = 1, apply M_EXCCode = 4 -> Req = 0. Then EXLClr = 1 -> next cycle EXL = 0 and Req = 1 if the cause persists.
- WE = 1, A2 = 14, DIn = 32'h0000_3400 in the same cycle as M_EXCCode = 12 -> EPC = M_PC, not 32'h3400.
- CP0_TIMER_EN: SR = 32'h0000_8001, Compare = 5, Count = 0 -> TimerPend and Req assert when Count reaches 5. Writing Compare clears TimerPend.
